// File: rtl/show_pkg.sv
// Shared types and constants for the Simon Says sequence playback block.
package show_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } show_state_e;

    localparam int COLOUR_W        = 2;
    localparam int LED_W           = 4;
    localparam int MAX_SEQ_LEN     = 16;
    localparam int SEQ_W           = COLOUR_W * MAX_SEQ_LEN;
    localparam int IDX_W           = $clog2(MAX_SEQ_LEN);

    localparam int DEF_ON_CYCLES   = 4;
    localparam int DEF_OFF_CYCLES  = 2;
    localparam int DEF_TONE_DIV    = 8;

    function automatic logic [LED_W-1:0] colour_to_led(input logic [COLOUR_W-1:0] code);
        return LED_W'(1) << code;
    endfunction

endpackage

// File: rtl/show_timer.sv
// Loadable down counter that halts at zero; zero flag is combinational from the count.
module show_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/show_state.sv
// Plays a latched colour sequence as one-hot LED pulses separated by dark gaps.
// Optional buzzer divider is built only when SHOW_TONE_EN is defined.
module show_state
    import show_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int TONE_DIV   = DEF_TONE_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rst_SHOW,
    input  logic                en_SHOW,
    input  logic [SEQ_W-1:0]    seq_val,
    input  logic [IDX_W-1:0]    seq_len,
    output logic [LED_W-1:0]    colour_led,
    output logic [COLOUR_W-1:0] colour_val,
    output logic                busy,
    output logic                complete_SHOW,
    output logic                tone
);

    localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TONE_DIV < 1) begin : g_param_err
        $error("show_state: ON_CYCLES, OFF_CYCLES and TONE_DIV must all be >= 1");
    end

    show_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [IDX_W-1:0]    len_q, len_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [COLOUR_W-1:0] val_q, val_d;
    logic                busy_q, busy_d;
    logic                cpl_q, cpl_d;
    logic [COLOUR_W-1:0] elem_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero;

    show_timer #(.W(TMR_W)) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        len_d    = len_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        if (rst_SHOW) begin
            state_d  = S_IDLE;
            idx_d    = '0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_SHOW) begin
                        seq_d    = seq_val;
                        len_d    = seq_len;
                        idx_d    = '0;
                        state_d  = S_ON;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(ON_CYCLES - 1);
                    end
                end
                S_ON: begin
                    if (tmr_zero) begin
                        state_d  = S_OFF;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(OFF_CYCLES - 1);
                    end
                end
                S_OFF: begin
                    if (tmr_zero) begin
                        if (idx_q == len_q) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d    = idx_q + 1'b1;
                            state_d  = S_ON;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(ON_CYCLES - 1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        elem_d = seq_d[{idx_d, 1'b0} +: COLOUR_W];
        led_d  = '0;
        val_d  = '0;
        busy_d = (state_d == S_ON) || (state_d == S_OFF);
        cpl_d  = (state_d == S_DONE);
        if (state_d == S_ON) begin
            led_d = colour_to_led(elem_d);
            val_d = elem_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            len_q   <= '0;
            led_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            cpl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            led_q   <= led_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            cpl_q   <= cpl_d;
        end
    end

    assign colour_led    = led_q;
    assign colour_val    = val_q;
    assign busy          = busy_q;
    assign complete_SHOW = cpl_q;

`ifdef SHOW_TONE_EN
    localparam int TONE_W = $clog2(TONE_DIV * 8);

    logic              tone_load;
    logic              tone_zero;
    logic [TONE_W-1:0] tone_val;
    logic              tone_q, tone_d;

    show_timer #(.W(TONE_W)) u_tone_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tone_load),
        .load_val (tone_val),
        .zero     (tone_zero)
    );

    // Half-period scales with the colour code; restart on every ON entry.
    always_comb begin
        tone_val  = TONE_W'((TONE_DIV << elem_d) - 1);
        tone_load = (state_d == S_ON) && ((state_q != S_ON) || tone_zero);
        tone_d    = 1'b0;
        if ((state_d == S_ON) && (state_q == S_ON)) begin
            tone_d = tone_zero ? ~tone_q : tone_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_q <= 1'b0;
        end else begin
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;
`else
    assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_show_state.sv
// Scoreboard bench for show_state: stimulus queues expected per-cycle outputs, monitor pops and compares.
module tb_show_state;

    localparam int ON_C  = 4;
    localparam int OFF_C = 2;
    localparam int TDIV  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_SHOW = 1'b0;
    logic        en_SHOW = 1'b0;
    logic [31:0] seq_val = '0;
    logic [3:0]  seq_len = '0;
    logic [3:0]  colour_led;
    logic [1:0]  colour_val;
    logic        busy;
    logic        complete_SHOW;
    logic        tone;

    show_state #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .TONE_DIV   (TDIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rst_SHOW      (rst_SHOW),
        .en_SHOW       (en_SHOW),
        .seq_val       (seq_val),
        .seq_len       (seq_len),
        .colour_led    (colour_led),
        .colour_val    (colour_val),
        .busy          (busy),
        .complete_SHOW (complete_SHOW),
        .tone          (tone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] led;
        logic [1:0] val;
        logic       bsy;
        logic       cpl;
        logic       tn;
        int         rel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   c0       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] led_of(input logic [1:0] c);
        case (c)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic tone_exp(input logic [1:0] c, input int j);
`ifdef SHOW_TONE_EN
        int p;
        p = TDIV << c;
        return ((j / p) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_play(input logic [31:0] s, input logic [3:0] l);
        exp_t       e;
        logic [1:0] c;
        int         r;
        r = 1;
        for (int n = 0; n <= int'(l); n++) begin
            c = s[2*n +: 2];
            for (int j = 0; j < ON_C; j++) begin
                e.led = led_of(c); e.val = c; e.bsy = 1'b1; e.cpl = 1'b0;
                e.tn = tone_exp(c, j); e.rel = r; r++;
                exp_q.push_back(e);
            end
            for (int j = 0; j < OFF_C; j++) begin
                e.led = 4'b0; e.val = 2'b0; e.bsy = 1'b1; e.cpl = 1'b0;
                e.tn = 1'b0; e.rel = r; r++;
                exp_q.push_back(e);
            end
        end
        e.led = 4'b0; e.val = 2'b0; e.bsy = 1'b0; e.cpl = 1'b1; e.tn = 1'b0; e.rel = r;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every active output cycle against the scoreboard head.
    always @(negedge clk) begin
        if (busy || complete_SHOW) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: busy=%0b complete=%0b led=%b, required nothing (cycle %0d)",
                         busy, complete_SHOW, colour_led, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("led",      32'(colour_led),    32'(mon_e.led));
                check("val",      32'(colour_val),    32'(mon_e.val));
                check("busy",     32'(busy),          32'(mon_e.bsy));
                check("complete", 32'(complete_SHOW), 32'(mon_e.cpl));
                check("tone",     32'(tone),          32'(mon_e.tn));
                check("rel_cycle", 32'(cyc - c0),     32'(mon_e.rel));
                $display("txn rel=%0d led=%b val=%0d busy=%0b cpl=%0b tone=%0b",
                         cyc - c0, colour_led, colour_val, busy, complete_SHOW, tone);
            end
        end else begin
            check("idle_led",  32'(colour_led), 32'd0);
            check("idle_val",  32'(colour_val), 32'd0);
            check("idle_tone", 32'(tone),       32'd0);
        end
    end

    task automatic start(input logic [31:0] s, input logic [3:0] l);
        @(negedge clk);
        seq_val = s;
        seq_len = l;
        en_SHOW = 1'b1;
        c0      = cyc;
        push_play(s, l);
        @(negedge clk);
        en_SHOW = 1'b0;
    endtask

    task automatic drain(input int maxc, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_led"},  32'(colour_led),    32'd0);
        check({name, "_val"},  32'(colour_val),    32'd0);
        check({name, "_busy"}, 32'(busy),          32'd0);
        check({name, "_cpl"},  32'(complete_SHOW), 32'd0);
        check({name, "_tone"}, 32'(tone),          32'd0);
    endtask

    initial begin
        // Reset held with a start request present.
        rst_n   = 1'b0;
        en_SHOW = 1'b1;
        seq_val = 32'h0000_00E4;
        seq_len = 4'd3;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n   = 1'b1;
        en_SHOW = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);

        // Full sequence 0,1,2,3.
        start(32'h0000_00E4, 4'd3);
        drain(60, "full_drain");

        // Snapshot: inputs scrambled and en_SHOW toggled through playback and DONE.
        start(32'h0000_001B, 4'd3);
        for (int i = 1; i <= 25; i++) begin
            seq_val = 32'hFFFF_FFFF;
            seq_len = 4'd0;
            en_SHOW = (i % 2 == 1) || (i == 25);
            @(negedge clk);
        end
        en_SHOW = 1'b0;
        drain(10, "snapshot_drain");

        // Maximum length.
        start(32'hFFFF_FFFF, 4'd15);
        drain(200, "maxlen_drain");

        // Abort in the second gap with a simultaneous start request.
        start(32'h0000_00E4, 4'd3);
        while (exp_q.size() > 11) void'(exp_q.pop_back());
        repeat (10) @(negedge clk);
        rst_SHOW = 1'b1;
        en_SHOW  = 1'b1;
        @(negedge clk);
        rst_SHOW = 1'b0;
        en_SHOW  = 1'b0;
        check_all_zero("abort");
        check("abort_leftover", 32'(exp_q.size()), 32'd0);
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-playback.
        start(32'h0000_00E4, 4'd3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/show_state.md
# show_state

Plays back a stored Simon Says colour sequence to the player before the input phase. It takes a snapshot of the 32-bit packed sequence from the memory block and the current round length. It then drives each 2-bit colour as a one-hot LED pattern for a fixed on-time, followed by a dark gap. When the last colour finishes, it pulses `complete_SHOW` so the top-level sequencing can enable the wait/input stage.

## Interface
- `ON_CYCLES`, default 4: clock cycles each colour is lit; must be at least 1.
- `OFF_CYCLES`, default 2: dark clock cycles after each colour; must be at least 1.
- `TONE_DIV`, default 8: base tone half-period in cycles; used only with `SHOW_TONE_EN`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rst_SHOW`  in  1  synchronous clear to IDLE; has priority over everything except `rst_n`.
- `en_SHOW`  in  1  start request; sampled in IDLE only.
- `seq_val`  in  32  packed sequence; element i is `seq_val[2i+1:2i]`, element 0 plays first.
- `seq_len`  in  4  number of colours to play minus 1 (0 plays 1 colour, 15 plays 16).
- `colour_led`  out  4  one-hot LED drive: 00→0001, 01→0010, 10→0100, 11→1000; 0000 when dark.
- `colour_val`  out  2  raw code of the element currently lit; 0 when dark.
- `busy`  out  1  high in ON and OFF.
- `complete_SHOW`  out  1  single-cycle pulse after the last gap.
- `tone`  out  1  square-wave buzzer drive; tied 0 without `SHOW_TONE_EN`.

## Operation
- States are IDLE, ON, OFF and DONE. All outputs are registered.
- IDLE → ON when `en_SHOW=1`. On that edge the block latches `seq_val` and `seq_len` into internal registers, sets index to 0 and loads the timer with ON_CYCLES−1.
- Input changes during playback have no effect.
- ON: `colour_led` and `colour_val` show latched element[index]. When the timer reaches 0, go to OFF and load OFF_CYCLES−1.
- OFF: LEDs are dark. When the timer reaches 0:
  - if index equals the latched length, go to DONE;
  - otherwise increment the index, go to ON and load ON_CYCLES−1.
- DONE: `complete_SHOW=1` and `busy=0` for exactly one cycle, then return to IDLE. `en_SHOW` is ignored in DONE.
- `en_SHOW` is ignored in ON and OFF; a restart is not possible mid-playback.
- `rst_SHOW=1` in any state forces IDLE on the next edge:
  - all outputs clear;
  - no `complete_SHOW` is issued;
  - a simultaneous `en_SHOW` is ignored.
- The index is 4 bits and never wraps. The maximum length of 16 ends on index 15.
- The timer is a down counter of width `$clog2(max(ON_CYCLES,OFF_CYCLES))`, minimum 1 bit.

## Timing
- Reset values: state IDLE, `colour_led=0`, `colour_val=0`, `busy=0`, `complete_SHOW=0`, `tone=0`, index 0, timer 0.
- Edge k samples `en_SHOW=1` in IDLE. Element 0 is visible and `busy=1` from cycle k+1.
- Each element is lit for exactly ON_CYCLES cycles, then dark for OFF_CYCLES cycles.
- `complete_SHOW` is high in cycle k+1+N·(ON_CYCLES+OFF_CYCLES), where N = `seq_len`+1.
- The earliest accepted restart is `en_SHOW` sampled one cycle after the `complete_SHOW` cycle.
- Asserting `rst_n` mid-operation clears everything immediately (asynchronously).

## Configuration
- Macro: `SHOW_TONE_EN`.
- Defined: during ON, `tone` toggles every `TONE_DIV<<colour_val` cycles. The divider counter restarts at each ON entry, and `tone` is forced to 0 outside ON.
- Undefined: no divider logic is built and `tone` is constant 0.

## Structure
- Package `show_pkg` holds:
  - the state enum (IDLE/ON/OFF/DONE);
  - the colour width constant 2 and the maximum sequence length 16;
  - a function mapping a colour code to the one-hot LED pattern;
  - the default ON/OFF/TONE_DIV values.
- Sub-module `show_timer`: a loadable down counter with `load`, `load_val` and a `zero` flag. It is instantiated once for the phase timing and, under `SHOW_TONE_EN`, once more for the tone divider.

## Test plan
- Reset: hold `rst_n=0` with `en_SHOW=1` → all outputs 0; release → still IDLE until the next sampled `en_SHOW`.
- Full sequence, ON=4, OFF=2, `seq_val=32'h0000_00E4`, `seq_len=3`, start at edge 0:
  - `colour_led` shows 0001, 0010, 0100, 1000, each for 4 cycles, separated by 2 dark cycles;
  - `colour_val` follows 0,1,2,3;
  - `complete_SHOW` is high in cycle 25 only.
- Snapshot: after the start, change `seq_val` to 32'hFFFF_FFFF and toggle `en_SHOW` → playback still matches the latched values and no restart occurs.
- Maximum length: `seq_val=32'hFFFF_FFFF`, `seq_len=15` → 16 lit pulses of 1000; `complete_SHOW` at cycle 1+16·6=97; the index does not wrap.
- Abort: `rst_SHOW=1` during the 2nd OFF phase together with `en_SHOW=1` → next cycle IDLE, all outputs 0, no `complete_SHOW`.
- `SHOW_TONE_EN`, TONE_DIV=2, colour 10: `tone` toggles every 8 cycles while lit and is 0 while dark; without the macro, `tone` stays 0 throughout.
